bcd_arbiter: RTL and testbench

Round-robin scheduler that shares one `bcd` converter instance between `NREQ` requesters. It does the following for each granted request:
- captures the requester's signed binary value;
- range-checks it;
- restarts the converter and waits for `data_ready`, guarded by a timeout;
- returns sign/hundreds/tens/ones on a shared result bus with a one-cycle per-requester `done` pulse.

The block sits between the display/telemetry clients and the single `bcd` datapath.

---
 rtl/bcd_arbiter.sv | 170 +++++++++++++++++
 tb/tb_bcd_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_arbiter
//  Description : Round-robin scheduler sharing one binary-to-BCD converter
//                between NREQ requesters. Each granted value is range-checked,
//                converted under a timeout guard, and returned on a shared
//                result bus with a one-cycle per-requester done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_arbiter #(
    parameter int N       = 16,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*N-1:0]   req_data,
    output logic [NREQ-1:0]     done,
    output logic                res_sign,
    output logic [3:0]          res_hundreds,
    output logic [3:0]          res_tens,
    output logic [3:0]          res_ones,
    output logic                res_err,
    output logic                busy,
    output logic                cnv_rst,
    output logic [N-1:0]        cnv_binary,
    input  logic                cnv_sign,
    input  logic [3:0]          cnv_hundreds,
    input  logic [3:0]          cnv_tens,
    input  logic [3:0]          cnv_ones,
    input  logic                cnv_data_ready
);

    localparam int c_IW = $clog2(NREQ);
    localparam int c_CW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_LAUNCH = 2'd1;
    localparam logic [1:0] c_WAIT   = 2'd2;
    localparam logic [1:0] c_DONE   = 2'd3;

    localparam logic signed [N-1:0] c_MAX = N'(999);
    localparam logic signed [N-1:0] c_MIN = N'(-999);

    logic [1:0]             r_state;
    logic [c_IW-1:0]        r_last;
    logic [c_IW-1:0]        r_win;
    logic [c_CW-1:0]        r_cnt;
    logic                   r_cnv_rst;
    logic [N-1:0]           r_cnv_binary;
    logic                   r_res_sign;
    logic [3:0]             r_res_hundreds;
    logic [3:0]             r_res_tens;
    logic [3:0]             r_res_ones;
    logic                   r_res_err;

    logic                   w_found;
    logic [c_IW-1:0]        w_win;
    logic [c_IW-1:0]        w_cand;
    logic [N-1:0]           w_data;
    logic signed [N-1:0]    w_sdata;
    logic                   w_in_range;

    // Round-robin search starting just after the last-served requester.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_last;
        w_cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = c_IW'((int'(r_last) + k) % NREQ);
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    assign w_data     = req_data[w_win*N +: N];
    assign w_sdata    = w_data;
    assign w_in_range = (w_sdata >= c_MIN) && (w_sdata <= c_MAX);

    // Transaction sequencer: grant, launch, wait for result or timeout, report.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_IDLE;
            r_last         <= c_IW'(NREQ - 1);
            r_win          <= '0;
            r_cnt          <= '0;
            r_cnv_rst      <= 1'b1;
            r_cnv_binary   <= '0;
            r_res_sign     <= 1'b0;
            r_res_hundreds <= 4'd0;
            r_res_tens     <= 4'd0;
            r_res_ones     <= 4'd0;
            r_res_err      <= 1'b0;
        end else begin
            r_cnv_rst <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_found) begin
                        r_win  <= w_win;
                        r_last <= w_win;
                        if (w_in_range) begin
                            // Restarting the converter discards any stale ready.
                            r_state      <= c_LAUNCH;
                            r_cnv_binary <= w_data;
                            r_cnv_rst    <= 1'b1;
                        end else begin
                            r_state        <= c_DONE;
                            r_res_sign     <= 1'b0;
                            r_res_hundreds <= 4'd0;
                            r_res_tens     <= 4'd0;
                            r_res_ones     <= 4'd0;
                            r_res_err      <= 1'b1;
                        end
                    end
                end
                c_LAUNCH: begin
                    r_state <= c_WAIT;
                    r_cnt   <= '0;
                end
                c_WAIT: begin
                    if (cnv_data_ready) begin
                        r_state        <= c_DONE;
                        r_res_sign     <= cnv_sign;
                        r_res_hundreds <= cnv_hundreds;
                        r_res_tens     <= cnv_tens;
                        r_res_ones     <= cnv_ones;
                        r_res_err      <= 1'b0;
                    end else if (r_cnt == c_CW'(TIMEOUT - 1)) begin
                        r_state        <= c_DONE;
                        r_res_sign     <= 1'b0;
                        r_res_hundreds <= 4'd0;
                        r_res_tens     <= 4'd0;
                        r_res_ones     <= 4'd0;
                        r_res_err      <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // One-hot done pulse to the requester being reported.
    always_comb begin
        done = '0;
        if (r_state == c_DONE) begin
            done[r_win] = 1'b1;
        end
    end

    assign busy         = (r_state != c_IDLE);
    assign cnv_rst      = r_cnv_rst;
    assign cnv_binary   = r_cnv_binary;
    assign res_sign     = r_res_sign;
    assign res_hundreds = r_res_hundreds;
    assign res_tens     = r_res_tens;
    assign res_ones     = r_res_ones;
    assign res_err      = r_res_err;

endmodule
`default_nettype wire

// File: tb/tb_bcd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_arbiter
//  Description : Directed self-checking bench for bcd_arbiter with a
//                behavioural converter model of configurable latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_arbiter;

    localparam int N       = 16;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 64;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req;
    logic [NREQ*N-1:0]   req_data;
    logic [NREQ-1:0]     done;
    logic                res_sign;
    logic [3:0]          res_hundreds;
    logic [3:0]          res_tens;
    logic [3:0]          res_ones;
    logic                res_err;
    logic                busy;
    logic                cnv_rst;
    logic [N-1:0]        cnv_binary;
    logic                cnv_sign       = 1'b0;
    logic [3:0]          cnv_hundreds   = 4'd0;
    logic [3:0]          cnv_tens       = 4'd0;
    logic [3:0]          cnv_ones       = 4'd0;
    logic                cnv_data_ready = 1'b0;

    int total = 0;
    int bad   = 0;

    int   m_delay = 18;
    logic m_en    = 1'b1;
    int   m_cnt   = 0;

    bcd_arbiter #(.N(N), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .done(done),
        .res_sign(res_sign), .res_hundreds(res_hundreds), .res_tens(res_tens),
        .res_ones(res_ones), .res_err(res_err), .busy(busy), .cnv_rst(cnv_rst),
        .cnv_binary(cnv_binary), .cnv_sign(cnv_sign), .cnv_hundreds(cnv_hundreds),
        .cnv_tens(cnv_tens), .cnv_ones(cnv_ones), .cnv_data_ready(cnv_data_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] conv(input logic [N-1:0] b);
        logic signed [N-1:0] s;
        int m;
        s = b;
        m = (s < 0) ? -int'(s) : int'(s);
        return {(s < 0), 4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    // Converter model: ready m_delay edges after the edge that samples cnv_rst.
    always @(posedge clk) begin
        if (cnv_rst) begin
            m_cnt          <= 0;
            cnv_data_ready <= 1'b0;
        end else begin
            if (m_cnt < m_delay) m_cnt <= m_cnt + 1;
            if (m_en && m_cnt == m_delay - 1) begin
                cnv_data_ready <= 1'b1;
                {cnv_sign, cnv_hundreds, cnv_tens, cnv_ones} <= conv(cnv_binary);
            end
        end
    end

    task automatic step(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_data(input int i, input int v);
        req_data[i*N +: N] = N'(v);
    endtask

    // Next edge is the grant edge; returns cycles to done, winner, cnv_rst cycles.
    task automatic run_txn(output int n, output int idx, output int rcnt,
                           output logic [N-1:0] bin1);
        n = -1; idx = -1; rcnt = 0; bin1 = '0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            #1;
            if (cnv_rst) rcnt++;
            if (c == 1) bin1 = cnv_binary;
            if (done != '0) begin
                n = c;
                for (int i = 0; i < NREQ; i++) if (done[i]) idx = i;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; req_data = '0;
        step(3);
        total++; if (done !== 4'b0) begin bad++; $display("FAIL reset_done: got %b expected 0000", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        total++; if ({res_sign, res_hundreds, res_tens, res_ones, res_err} !== 14'd0) begin
            bad++; $display("FAIL reset_res: got %h expected 0", {res_sign, res_hundreds, res_tens, res_ones, res_err}); end
        total++; if (cnv_binary !== 16'd0) begin bad++; $display("FAIL reset_cnv_binary: got %h expected 0", cnv_binary); end
        total++; if (cnv_rst !== 1'b1) begin bad++; $display("FAIL reset_cnv_rst: got %b expected 1", cnv_rst); end
        rst = 1'b0;
        step(1);
    endtask

    task automatic test_single();
        int n, idx, rcnt;
        logic [N-1:0] bin1;
        set_data(0, -162);
        req = 4'b0001;
        run_txn(n, idx, rcnt, bin1);
        req = 4'b0000;
        total++; if (n !== 21) begin bad++; $display("FAIL single_latency: got %0d expected 21", n); end
        total++; if (idx !== 0) begin bad++; $display("FAIL single_winner: got %0d expected 0", idx); end
        total++; if (rcnt !== 1) begin bad++; $display("FAIL single_cnv_rst: got %0d expected 1", rcnt); end
        total++; if (bin1 !== 16'hFF5E) begin bad++; $display("FAIL single_cnv_binary: got %h expected ff5e", bin1); end
        total++; if ({res_sign, res_hundreds, res_tens, res_ones, res_err} !== {1'b1, 4'd1, 4'd6, 4'd2, 1'b0}) begin
            bad++; $display("FAIL single_result: got %b/%0d/%0d/%0d err=%b expected 1/1/6/2 err=0",
                            res_sign, res_hundreds, res_tens, res_ones, res_err); end
        step(1);
    endtask

    task automatic test_contention();
        int n, idx, rcnt;
        logic [N-1:0] bin1;
        do_reset();
        set_data(1, 38); set_data(3, 999);
        req = 4'b1010;
        run_txn(n, idx, rcnt, bin1);
        req[1] = 1'b0;
        total++; if (idx !== 1 || n !== 21) begin bad++; $display("FAIL cont_first: got idx=%0d n=%0d expected idx=1 n=21", idx, n); end
        total++; if ({res_sign, res_hundreds, res_tens, res_ones, res_err} !== {1'b0, 4'd0, 4'd3, 4'd8, 1'b0}) begin
            bad++; $display("FAIL cont_result1: got %b/%0d/%0d/%0d err=%b expected 0/0/3/8 err=0",
                            res_sign, res_hundreds, res_tens, res_ones, res_err); end
        step(1);
        run_txn(n, idx, rcnt, bin1);
        req[3] = 1'b0;
        total++; if (idx !== 3 || n !== 21) begin bad++; $display("FAIL cont_second: got idx=%0d n=%0d expected idx=3 n=21", idx, n); end
        total++; if ({res_sign, res_hundreds, res_tens, res_ones, res_err} !== {1'b0, 4'd9, 4'd9, 4'd9, 1'b0}) begin
            bad++; $display("FAIL cont_result3: got %b/%0d/%0d/%0d err=%b expected 0/9/9/9 err=0",
                            res_sign, res_hundreds, res_tens, res_ones, res_err); end
        step(1);
        // With last at 3, requester 0 must beat requester 2.
        set_data(0, 0); set_data(2, 0);
        req = 4'b0101;
        run_txn(n, idx, rcnt, bin1);
        req = 4'b0000;
        total++; if (idx !== 0) begin bad++; $display("FAIL cont_last: got %0d expected 0", idx); end
        step(1);
    endtask

    task automatic test_range();
        int n, idx, rcnt;
        logic [N-1:0] bin1;
        int vals [3] = '{1000, -1000, -32768};
        for (int i = 0; i < 3; i++) begin
            set_data(i, vals[i]);
            req = 4'b0001 << i;
            run_txn(n, idx, rcnt, bin1);
            req = 4'b0000;
            total++; if (n !== 1 || idx !== i) begin
                bad++; $display("FAIL range_latency[%0d]: got n=%0d idx=%0d expected n=1 idx=%0d", i, n, idx, i); end
            total++; if ({res_sign, res_hundreds, res_tens, res_ones, res_err} !== {13'd0, 1'b1}) begin
                bad++; $display("FAIL range_result[%0d]: got %b/%0d/%0d/%0d err=%b expected 0/0/0/0 err=1",
                                i, res_sign, res_hundreds, res_tens, res_ones, res_err); end
            total++; if (rcnt !== 0) begin bad++; $display("FAIL range_cnv_rst[%0d]: got %0d expected 0", i, rcnt); end
            step(1);
        end
    endtask

    task automatic test_timeout();
        int n, idx, rcnt;
        logic [N-1:0] bin1;
        m_en = 1'b0;
        set_data(0, 5);
        req = 4'b0001;
        run_txn(n, idx, rcnt, bin1);
        req = 4'b0000;
        total++; if (n !== 66 || idx !== 0) begin bad++; $display("FAIL timeout_latency: got n=%0d idx=%0d expected n=66 idx=0", n, idx); end
        total++; if ({res_sign, res_hundreds, res_tens, res_ones, res_err} !== {13'd0, 1'b1}) begin
            bad++; $display("FAIL timeout_result: got %b/%0d/%0d/%0d err=%b expected 0/0/0/0 err=1",
                            res_sign, res_hundreds, res_tens, res_ones, res_err); end
        step(1);
        m_en = 1'b1;
        set_data(1, -7);
        req = 4'b0010;
        run_txn(n, idx, rcnt, bin1);
        req = 4'b0000;
        total++; if (n !== 21 || idx !== 1) begin bad++; $display("FAIL after_timeout_latency: got n=%0d idx=%0d expected n=21 idx=1", n, idx); end
        total++; if ({res_sign, res_hundreds, res_tens, res_ones, res_err} !== {1'b1, 4'd0, 4'd0, 4'd7, 1'b0}) begin
            bad++; $display("FAIL after_timeout_result: got %b/%0d/%0d/%0d err=%b expected 1/0/0/7 err=0",
                            res_sign, res_hundreds, res_tens, res_ones, res_err); end
        step(1);
    endtask

    task automatic test_fairness();
        int n, idx, rcnt;
        logic [N-1:0] bin1;
        do_reset();
        m_delay = 3;
        for (int i = 0; i < NREQ; i++) set_data(i, 123);
        req = 4'b1111;
        for (int t = 0; t < 12; t++) begin
            run_txn(n, idx, rcnt, bin1);
            total++; if (idx !== t % 4 || n !== 6) begin
                bad++; $display("FAIL fair_order[%0d]: got idx=%0d n=%0d expected idx=%0d n=6", t, idx, n, t % 4); end
            total++; if (rcnt !== 1 || {res_sign, res_hundreds, res_tens, res_ones, res_err} !== {1'b0, 4'd1, 4'd2, 4'd3, 1'b0}) begin
                bad++; $display("FAIL fair_launch[%0d]: got rst_cycles=%0d res=%b/%0d/%0d/%0d err=%b expected 1 and 0/1/2/3 err=0",
                                t, rcnt, res_sign, res_hundreds, res_tens, res_ones, res_err); end
            step(1);
        end
        req = 4'b0000;
        m_delay = 18;
        step(1);
    endtask

    task automatic test_reset_mid_wait();
        int n, idx, rcnt;
        logic [N-1:0] bin1;
        set_data(1, 42);
        req = 4'b0010;
        for (int c = 1; c <= 6; c++) begin
            step(1);
            total++; if (done !== 4'b0) begin bad++; $display("FAIL rmw_early_done[%0d]: got %b expected 0000", c, done); end
        end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rmw_busy: got %b expected 1", busy); end
        rst = 1'b1;
        step(1);
        total++; if (done !== 4'b0 || busy !== 1'b0 || cnv_rst !== 1'b1 || cnv_binary !== 16'd0) begin
            bad++; $display("FAIL rmw_ctrl: got done=%b busy=%b cnv_rst=%b cnv_binary=%h expected 0000/0/1/0000",
                            done, busy, cnv_rst, cnv_binary); end
        total++; if ({res_sign, res_hundreds, res_tens, res_ones, res_err} !== 14'd0) begin
            bad++; $display("FAIL rmw_res: got %h expected 0", {res_sign, res_hundreds, res_tens, res_ones, res_err}); end
        step(2);
        total++; if (done !== 4'b0) begin bad++; $display("FAIL rmw_no_done: got %b expected 0000", done); end
        rst = 1'b0;
        req = 4'b0111;
        run_txn(n, idx, rcnt, bin1);
        req = 4'b0000;
        total++; if (idx !== 0 || n !== 21) begin bad++; $display("FAIL rmw_first: got idx=%0d n=%0d expected idx=0 n=21", idx, n); end
        step(1);
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_range();
        test_timeout();
        test_fairness();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
